alu_mc: RTL
===========

ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001: Parameter WIDTH, default 32, datapath width in bits; legal values 8..64.
REQ-002: Parameter SHW, default $clog2(WIDTH), shift-amount width; derived, not overridden.
REQ-003: clk  input  1  single clock; all state changes on its rising edge.
REQ-004: reset  input  1  asynchronous, active-high reset.
REQ-005: Start  input  1  request to begin an operation; sampled on the rising edge of clk.
REQ-006: a  input  WIDTH  first operand.
REQ-007: b  input  WIDTH  second operand; low SHW bits are the shift amount for shift ops.
REQ-008: ALUControl  input  3  op select: 000 ADD, 001 SUB, 010 AND, 011 ORR, 100 EOR, 101 MUL, 110 LSL, 111 LSR.
REQ-009: Busy  output  1  high while a multicycle MUL is in progress.
REQ-010: Done  output  1  one-cycle completion pulse.
REQ-011: Result  output  WIDTH  registered result of the last completed operation.
REQ-012: ALUFlags  output  4  registered {N, Z, C, V} of the last completed operation.

Function
REQ-013: The FSM SHALL have exactly three states: IDLE, MUL, DONE.
REQ-014: In IDLE with Start=1 the block SHALL latch a, b and ALUControl on that edge; later operand changes SHALL have no effect.
REQ-015: Non-MUL ops SHALL update Result and ALUFlags on the Start edge, go to DONE, and drive Done=1 for exactly the following cycle; Busy stays 0.
REQ-016: MUL SHALL go to MUL, set Busy=1, and run one shift-add iteration per cycle for WIDTH cycles; on the WIDTH-th edge after Start it SHALL update Result/ALUFlags, clear Busy, and enter DONE.
REQ-017: DONE SHALL assert Done for one cycle and return to IDLE unconditionally; Start in DONE SHALL be ignored.
REQ-018: Start while Busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-019: ADD/SUB: WIDTH+1-bit sum of a + (b or ~b) + sub; Result = low WIDTH bits.
REQ-020: MUL: Result = low WIDTH bits of the unsigned product; upper bits discarded.
REQ-021: LSL/LSR: logical shift of a by b[SHW-1:0]; vacated bits are zero.
REQ-022: N = Result[WIDTH-1]; Z = (Result == 0), for every op.
REQ-023: C: ADD/SUB = carry-out bit WIDTH; LSL/LSR = last bit shifted out, 0 when amount is 0; AND/ORR/EOR/MUL = 0.
REQ-024: V: ADD/SUB = signed two's-complement overflow; all other ops = 0.
REQ-025: Result and ALUFlags SHALL hold their values between completions; they SHALL NOT change during MUL iterations.

Reset
REQ-026: reset=1 SHALL immediately force state IDLE, Busy=0, Done=0, Result=0, ALUFlags=0, and clear all internal accumulators.
REQ-027: reset during MUL SHALL abort the operation with no Done pulse; the first Start after reset deasserts SHALL be accepted normally.

Structure
REQ-028: Shared package alu_pkg SHALL hold the 3-bit op encodings, the state enum (IDLE/MUL/DONE), and flag bit indices (N=3, Z=2, C=1, V=0).
REQ-029: The iterative multiplier SHALL be one sub-module, alu_mul_seq (WIDTH param; load, step, product), controlled by the alu_mc FSM.
REQ-030: Add/sub, logic and barrel-shift paths SHALL stay combinational inside alu_mc, with a single registered output stage.

Verification (WIDTH=32 unless stated)
REQ-031: ADD 0x7FFFFFFF + 0x00000001 -> Result 0x80000000, flags 1001, Done one cycle after the Start edge, Busy never high.
REQ-032: SUB 5 - 5 -> Result 0, flags 0110; SUB 0 - 1 -> 0xFFFFFFFF, flags 1000.
REQ-033: MUL 0x00010003 * 0x00000005 -> 0x0005000F, flags 0000; Busy high exactly 32 cycles and Done on the 33rd; a Start pulse at cycle 5 is ignored, with no second Done.
REQ-034: LSL 0x80000001 by 1 -> 0x00000002, C=1; LSR 0x0000000F by 0 -> 0x0000000F, C=0; LSR 0x1 by 31 -> 0, Z=1.
REQ-035: reset asserted asynchronously at MUL cycle 10 -> Busy/Done/Result/ALUFlags all 0 before the next clk edge and no Done pulse; the next ADD 2+3 -> 5.
REQ-036: WIDTH=8 instance: MUL 0x10 * 0x11 -> Result 0x10 after 8 busy cycles; ADD 0xFF + 0x01 -> 0x00, flags 0110.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared op encodings, FSM state type and flag bit positions
//               for the multicycle ALU.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam logic [2:0] c_op_add = 3'b000;
    localparam logic [2:0] c_op_sub = 3'b001;
    localparam logic [2:0] c_op_and = 3'b010;
    localparam logic [2:0] c_op_orr = 3'b011;
    localparam logic [2:0] c_op_eor = 3'b100;
    localparam logic [2:0] c_op_mul = 3'b101;
    localparam logic [2:0] c_op_lsl = 3'b110;
    localparam logic [2:0] c_op_lsr = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int c_flag_n = 3;
    localparam int c_flag_z = 2;
    localparam int c_flag_c = 1;
    localparam int c_flag_v = 0;

    function automatic logic [3:0] pack_flags(input logic n, input logic z,
                                              input logic c, input logic v);
        logic [3:0] f;
        f = '0;
        f[c_flag_n] = n;
        f[c_flag_z] = z;
        f[c_flag_c] = c;
        f[c_flag_v] = v;
        return f;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_mul_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_mul_seq
// Description : Iterative shift-add multiplier keeping the low WIDTH bits of
//               the unsigned product; one partial product per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_mul_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] product
);

    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;

    // load already folds in the first partial product (bit 0 of b), so the
    // controller issues WIDTH-1 further steps to consume the remaining bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else if (load) begin
            r_acc    <= b[0] ? a : '0;
            r_mcand  <= a << 1;
            r_mplier <= b >> 1;
        end else if (step) begin
            if (r_mplier[0]) begin
                r_acc <= r_acc + r_mcand;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
        end
    end

    assign product = r_acc;

endmodule
`default_nettype wire

// File: rtl/alu_mc.sv
`default_nettype none
// ============================================================================
// Module      : alu_mc
// Description : Multicycle ALU: single-cycle add/sub/logic/shift, iterative
//               multiply, registered Result/ALUFlags and a Done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       ALUControl,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic [3:0]       ALUFlags
);

    localparam logic [SHW-1:0] c_cnt_last = SHW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [SHW-1:0]   r_cnt;
    logic [WIDTH-1:0] r_result;
    logic [3:0]       r_flags;

    logic             w_mul_load;
    logic             w_mul_step;
    logic             w_out_en;
    logic             w_out_from_mul;
    logic [WIDTH-1:0] w_product;

    // ------------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_mul_load     = 1'b0;
        w_mul_step     = 1'b0;
        w_out_en       = 1'b0;
        w_out_from_mul = 1'b0;
        Busy           = (r_state == MUL);
        Done           = (r_state == DONE);
        case (r_state)
            IDLE: begin
                if (Start) begin
                    if (ALUControl == c_op_mul) begin
                        w_mul_load   = 1'b1;
                        w_state_next = MUL;
                    end else begin
                        w_out_en     = 1'b1;
                        w_state_next = DONE;
                    end
                end
            end
            MUL: begin
                if (r_cnt == c_cnt_last) begin
                    w_out_en       = 1'b1;
                    w_out_from_mul = 1'b1;
                    w_state_next   = DONE;
                end else begin
                    w_mul_step = 1'b1;
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_mul_load) begin
            r_cnt <= '0;
        end else if (w_mul_step) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // The multiplier captures a and b itself, so operand changes after the
    // Start edge cannot disturb a running multiply.
    alu_mul_seq #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst     (reset),
        .load    (w_mul_load),
        .step    (w_mul_step),
        .a       (a),
        .b       (b),
        .product (w_product)
    );

    // ------------------------------------------------------------------------
    // Single-cycle datapath
    // ------------------------------------------------------------------------
    logic [SHW-1:0]   w_shamt;
    logic             w_is_sub;
    logic [WIDTH-1:0] w_b_op;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shl;
    logic [WIDTH:0]   w_shr;
    logic [WIDTH-1:0] w_alu_res;
    logic             w_alu_c;
    logic             w_alu_v;

    assign w_shamt  = b[SHW-1:0];
    assign w_is_sub = (ALUControl == c_op_sub);
    assign w_b_op   = w_is_sub ? ~b : b;
    assign w_sum    = {1'b0, a} + {1'b0, w_b_op} + {{WIDTH{1'b0}}, w_is_sub};

    // One spare bit on each shift catches the last bit shifted out; a zero
    // amount leaves that spare bit at 0, which is the required carry.
    assign w_shl = {1'b0, a} << w_shamt;
    assign w_shr = {a, 1'b0} >> w_shamt;

    always_comb begin
        w_alu_res = '0;
        w_alu_c   = 1'b0;
        w_alu_v   = 1'b0;
        case (ALUControl)
            c_op_add, c_op_sub: begin
                w_alu_res = w_sum[WIDTH-1:0];
                w_alu_c   = w_sum[WIDTH];
                w_alu_v   = (a[WIDTH-1] == w_b_op[WIDTH-1]) &&
                            (w_sum[WIDTH-1] != a[WIDTH-1]);
            end
            c_op_and: w_alu_res = a & b;
            c_op_orr: w_alu_res = a | b;
            c_op_eor: w_alu_res = a ^ b;
            c_op_lsl: begin
                w_alu_res = w_shl[WIDTH-1:0];
                w_alu_c   = w_shl[WIDTH];
            end
            c_op_lsr: begin
                w_alu_res = w_shr[WIDTH:1];
                w_alu_c   = w_shr[0];
            end
            default: begin
                w_alu_res = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Registered output stage shared by every op
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] w_out_res;
    logic             w_out_c;
    logic             w_out_v;
    logic [3:0]       w_out_flags;

    assign w_out_res   = w_out_from_mul ? w_product : w_alu_res;
    assign w_out_c     = w_out_from_mul ? 1'b0 : w_alu_c;
    assign w_out_v     = w_out_from_mul ? 1'b0 : w_alu_v;
    assign w_out_flags = pack_flags(w_out_res[WIDTH-1], (w_out_res == '0),
                                    w_out_c, w_out_v);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_result <= '0;
            r_flags  <= '0;
        end else if (w_out_en) begin
            r_result <= w_out_res;
            r_flags  <= w_out_flags;
        end
    end

    assign Result   = r_result;
    assign ALUFlags = r_flags;

endmodule
`default_nettype wire
